serial_subtractor: RTL



---
 rtl/alu_pkg.sv | 13 +
 rtl/half_subtractor.sv | 12 +
 rtl/serial_subtractor.sv | 126 ++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: FSM encodings and the default datapath width used by
// the adder and subtractor paths.
package alu_pkg;

  localparam int unsigned DefaultWidth = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/half_subtractor.sv
// Single-bit half subtractor: x - y with borrow out.
module half_subtractor (
  input  logic x,
  input  logic y,
  output logic diff,
  output logic bout
);

  assign diff = x ^ y;
  assign bout = ~x & y;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial A - B, LSB first, one bit per clock, with start/done handshake
// and unsigned borrow, signed overflow and zero flags.
module serial_subtractor
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             borrow,
  output logic             overflow,
  output logic             zero
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, b_q, diff_q;
  logic [CntW-1:0]   cnt_q;
  logic              bin_q;
  logic              amsb_q, bmsb_q;
  logic [WIDTH-1:0]  result_q;
  logic              borrow_q, overflow_q, zero_q;

  logic              d1, bout1, d, bout2, bout;
  logic              last;
  logic [WIDTH-1:0]  diff_next;

  // Full-subtract cell: (a0 - b0) first, then subtract the incoming borrow.
  half_subtractor u_hs0 (
    .x    (a_q[0]),
    .y    (b_q[0]),
    .diff (d1),
    .bout (bout1)
  );

  half_subtractor u_hs1 (
    .x    (d1),
    .y    (bin_q),
    .diff (d),
    .bout (bout2)
  );

  assign bout      = bout1 | bout2;
  assign last      = (cnt_q == CntW'(WIDTH - 1));
  assign diff_next = {d, diff_q[WIDTH-1:1]};

  always_comb begin
    state_d = state_q;
    ready   = 1'b0;
    done    = 1'b0;
    case (state_q)
      S_RUN: begin
        if (last) state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        // Unused encoding 2'd3 behaves as idle.
        ready = 1'b1;
        if (start) state_d = S_RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      diff_q     <= '0;
      cnt_q      <= '0;
      bin_q      <= 1'b0;
      amsb_q     <= 1'b0;
      bmsb_q     <= 1'b0;
      result_q   <= '0;
      borrow_q   <= 1'b0;
      overflow_q <= 1'b0;
      zero_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_RUN: begin
          a_q    <= {1'b0, a_q[WIDTH-1:1]};
          b_q    <= {1'b0, b_q[WIDTH-1:1]};
          diff_q <= diff_next;
          bin_q  <= bout;
          cnt_q  <= cnt_q + CntW'(1);
          // Publish on the final bit so outputs are valid while done is high.
          if (last) begin
            result_q   <= diff_next;
            borrow_q   <= bout;
            overflow_q <= (amsb_q != bmsb_q) && (d != amsb_q);
            zero_q     <= (diff_next == '0);
          end
        end
        S_DONE: ;
        default: begin
          if (start) begin
            a_q    <= a;
            b_q    <= b;
            amsb_q <= a[WIDTH-1];
            bmsb_q <= b[WIDTH-1];
            diff_q <= '0;
            cnt_q  <= '0;
            bin_q  <= 1'b0;
          end
        end
      endcase
    end
  end

  assign result   = result_q;
  assign borrow   = borrow_q;
  assign overflow = overflow_q;
  assign zero     = zero_q;

endmodule
